// File: rtl/mem_access_unit.sv
// MEM-stage memory access controller: issues one request/acknowledge RAM access per
// aligned load/store, stalls upstream while it is outstanding, and registers MEM/WB.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_ex_mem,
  input  logic              MemRead_ex_mem,
  input  logic              MemWrite_ex_mem,
  input  logic              RegWrite_ex_mem,
  input  logic              MemtoReg_ex_mem,
  input  logic              halt_ex_mem,
  input  logic [ADDR_W-1:0] alu_out_ex_mem,
  input  logic [DATA_W-1:0] ram_write_data_ex_mem,
  input  logic [4:0]        write_reg_ex_mem,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              mem_stall,
  output logic [31:0]       pc_mem_wb,
  output logic [ADDR_W-1:0] alu_out_mem_wb,
  output logic [DATA_W-1:0] ram_read_data_mem_wb,
  output logic              RegWrite_mem_wb,
  output logic              MemtoReg_mem_wb,
  output logic              halt_mem_wb,
  output logic [4:0]        write_reg_mem_wb,
  output logic              addr_err_mem_wb,
  output logic              bus_err_mem_wb
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              bus_err_q, bus_err_nxt;
  logic [DATA_W-1:0] rbuf, rbuf_nxt;

  logic              req_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  logic [31:0]       wb_pc_d;
  logic [ADDR_W-1:0] wb_alu_d;
  logic [DATA_W-1:0] wb_rdata_d;
  logic              wb_rw_d, wb_m2r_d, wb_halt_d, wb_aerr_d, wb_berr_d;
  logic [4:0]        wb_wr_d;

  logic is_mem, aligned, is_access;

  assign is_mem    = MemRead_ex_mem | MemWrite_ex_mem;
  assign aligned   = (alu_out_ex_mem[1:0] == 2'b00);
  assign is_access = is_mem & aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Everything registered defaults to a bubble / hold; each state overrides what it owns.
  always_comb begin
    state_nxt   = state;
    mem_stall   = 1'b0;
    cnt_nxt     = cnt;
    bus_err_nxt = bus_err_q;
    rbuf_nxt    = rbuf;
    req_nxt     = ram_req;
    we_nxt      = ram_we;
    addr_nxt    = ram_addr;
    wdata_nxt   = ram_wdata;
    wb_pc_d     = '0;
    wb_alu_d    = '0;
    wb_rdata_d  = '0;
    wb_rw_d     = 1'b0;
    wb_m2r_d    = 1'b0;
    wb_halt_d   = 1'b0;
    wb_wr_d     = '0;
    wb_aerr_d   = 1'b0;
    wb_berr_d   = 1'b0;

    case (state)
      IDLE: begin
        if (is_access) begin
          mem_stall = 1'b1;
          req_nxt   = 1'b1;
          we_nxt    = MemWrite_ex_mem;
          addr_nxt  = {alu_out_ex_mem[ADDR_W-1:2], 2'b00};
          wdata_nxt = ram_write_data_ex_mem;
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          wb_pc_d   = pc_ex_mem;
          wb_alu_d  = alu_out_ex_mem;
          wb_rw_d   = RegWrite_ex_mem;
          wb_m2r_d  = MemtoReg_ex_mem;
          wb_halt_d = halt_ex_mem;
          wb_wr_d   = write_reg_ex_mem;
          if (is_mem) begin
            wb_rw_d   = 1'b0;
            wb_m2r_d  = 1'b0;
            wb_aerr_d = 1'b1;
          end
        end
      end

      // An acknowledge in the last allowed cycle still wins over the timeout.
      WAIT: begin
        mem_stall = 1'b1;
        if (ram_ack) begin
          req_nxt   = 1'b0;
          state_nxt = DONE;
          if (!ram_we) begin
            rbuf_nxt = ram_rdata;
          end
        end else if (cnt == CNT_LAST) begin
          req_nxt     = 1'b0;
          bus_err_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        wb_pc_d     = pc_ex_mem;
        wb_alu_d    = alu_out_ex_mem;
        wb_rdata_d  = rbuf;
        wb_rw_d     = RegWrite_ex_mem;
        wb_m2r_d    = MemtoReg_ex_mem;
        wb_halt_d   = halt_ex_mem;
        wb_wr_d     = write_reg_ex_mem;
        if (bus_err_q) begin
          wb_rw_d   = 1'b0;
          wb_m2r_d  = 1'b0;
          wb_berr_d = 1'b1;
        end
        bus_err_nxt = 1'b0;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bus_err_q <= 1'b0;
      rbuf      <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      cnt       <= cnt_nxt;
      bus_err_q <= bus_err_nxt;
      rbuf      <= rbuf_nxt;
      ram_req   <= req_nxt;
      ram_we    <= we_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mem_wb            <= '0;
      alu_out_mem_wb       <= '0;
      ram_read_data_mem_wb <= '0;
      RegWrite_mem_wb      <= 1'b0;
      MemtoReg_mem_wb      <= 1'b0;
      halt_mem_wb          <= 1'b0;
      write_reg_mem_wb     <= '0;
      addr_err_mem_wb      <= 1'b0;
      bus_err_mem_wb       <= 1'b0;
    end else begin
      pc_mem_wb            <= wb_pc_d;
      alu_out_mem_wb       <= wb_alu_d;
      ram_read_data_mem_wb <= wb_rdata_d;
      RegWrite_mem_wb      <= wb_rw_d;
      MemtoReg_mem_wb      <= wb_m2r_d;
      halt_mem_wb          <= wb_halt_d;
      write_reg_mem_wb     <= wb_wr_d;
      addr_err_mem_wb      <= wb_aerr_d;
      bus_err_mem_wb       <= wb_berr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues instructions and predicts the
// MEM/WB result, a RAM model answers requests, and a monitor checks MEM/WB in order.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk, rst_n;
  logic [31:0] pc_ex_mem, alu_out_ex_mem, ram_write_data_ex_mem;
  logic        MemRead_ex_mem, MemWrite_ex_mem, RegWrite_ex_mem, MemtoReg_ex_mem, halt_ex_mem;
  logic [4:0]  write_reg_ex_mem;
  logic        ram_req, ram_we, ram_ack, mem_stall;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] pc_mem_wb, alu_out_mem_wb, ram_read_data_mem_wb;
  logic        RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb, addr_err_mem_wb, bus_err_mem_wb;
  logic [4:0]  write_reg_mem_wb;

  typedef struct {
    logic [31:0] pc, alu, rdata;
    logic        rw, m2r, halt, aerr, berr, chk_rd;
    logic [4:0]  wr;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    int          lat, req_cycles;
  } ram_t;

  exp_t exp_q[$];
  ram_t ram_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_ex_mem(pc_ex_mem),
    .MemRead_ex_mem(MemRead_ex_mem), .MemWrite_ex_mem(MemWrite_ex_mem),
    .RegWrite_ex_mem(RegWrite_ex_mem), .MemtoReg_ex_mem(MemtoReg_ex_mem),
    .halt_ex_mem(halt_ex_mem),
    .alu_out_ex_mem(alu_out_ex_mem), .ram_write_data_ex_mem(ram_write_data_ex_mem),
    .write_reg_ex_mem(write_reg_ex_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .mem_stall(mem_stall),
    .pc_mem_wb(pc_mem_wb), .alu_out_mem_wb(alu_out_mem_wb),
    .ram_read_data_mem_wb(ram_read_data_mem_wb),
    .RegWrite_mem_wb(RegWrite_mem_wb), .MemtoReg_mem_wb(MemtoReg_mem_wb),
    .halt_mem_wb(halt_mem_wb), .write_reg_mem_wb(write_reg_mem_wb),
    .addr_err_mem_wb(addr_err_mem_wb), .bus_err_mem_wb(bus_err_mem_wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic driveInputs(input logic mr, mw, rw, m2r, hlt, input logic [31:0] pc, alu,
                             wdata, input logic [4:0] wr);
    MemRead_ex_mem        = mr;
    MemWrite_ex_mem       = mw;
    RegWrite_ex_mem       = rw;
    MemtoReg_ex_mem       = m2r;
    halt_ex_mem           = hlt;
    pc_ex_mem             = pc;
    alu_out_ex_mem        = alu;
    ram_write_data_ex_mem = wdata;
    write_reg_ex_mem      = wr;
  endtask

  // Reference model: latency and MEM/WB contents follow directly from the access rules.
  task automatic applyStimulus(input logic mr, mw, rw, m2r, hlt, input logic [31:0] pc, alu,
                               wdata, input logic [4:0] wr, input int lat,
                               input logic [31:0] rdata);
    exp_t e;
    ram_t r;
    bit   is_mem, aligned, access, tmo;
    int   n, stalls;
    is_mem  = mr || mw;
    aligned = (alu % 4) == 0;
    access  = is_mem && aligned;
    tmo     = access && (lat == 0 || lat > T);
    n       = tmo ? T : lat;
    @(posedge clk);
    #1;
    e.pc     = pc;
    e.alu    = alu;
    e.wr     = wr;
    e.halt   = hlt;
    e.aerr   = is_mem && !aligned;
    e.berr   = tmo;
    e.rw     = (e.aerr || e.berr) ? 1'b0 : rw;
    e.m2r    = (e.aerr || e.berr) ? 1'b0 : m2r;
    e.chk_rd = access && !mw && !tmo;
    e.rdata  = rdata;
    e.cyc    = cyc + (access ? n + 2 : 1);
    exp_q.push_back(e);
    if (access) begin
      r.we = mw; r.addr = alu; r.wdata = wdata; r.rdata = rdata;
      r.lat = lat; r.req_cycles = n;
      ram_q.push_back(r);
    end
    driveInputs(mr, mw, rw, m2r, hlt, pc, alu, wdata, wr);
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
    end
    checkOutput("stall_cycles", 32'(stalls), 32'(access ? n + 1 : 0));
  endtask

  // RAM model: acknowledges after the chosen number of WAIT cycles, random acks when idle.
  initial begin
    int   wcnt;
    ram_t cur;
    wcnt = 0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, lat: 0, req_cycles: 0};
    ram_ack = 1'b0;
    ram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wcnt = 0;
        ram_ack = 1'b0;
      end else if (ram_req) begin
        if (wcnt == 0) begin
          checkOutput("ram_txn_expected", 32'(ram_q.size() > 0), 32'd1);
          if (ram_q.size() > 0) cur = ram_q.pop_front();
        end
        wcnt++;
        checkOutput("ram_we", 32'(ram_we), 32'(cur.we));
        checkOutput("ram_addr", ram_addr, cur.addr);
        checkOutput("ram_wdata", ram_wdata, cur.wdata);
        ram_ack = (cur.lat != 0) && (wcnt == cur.lat);
        ram_rdata = ram_ack ? cur.rdata : $urandom();
      end else begin
        if (wcnt != 0) checkOutput("ram_req_cycles", 32'(wcnt), 32'(cur.req_cycles));
        wcnt = 0;
        ram_ack = ($urandom_range(0, 1) == 1);
        ram_rdata = $urandom();
      end
    end
  end

  // Monitor: any MEM/WB entry with a nonzero PC is an instruction, otherwise a bubble.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (pc_mem_wb != 32'h0) begin
          checkOutput("wb_expected_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("wb_pc", pc_mem_wb, e.pc);
            checkOutput("wb_alu_out", alu_out_mem_wb, e.alu);
            checkOutput("wb_ctrl", 32'({RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb,
                                        addr_err_mem_wb, bus_err_mem_wb}),
                        32'({e.rw, e.m2r, e.halt, e.aerr, e.berr}));
            checkOutput("wb_write_reg", 32'(write_reg_mem_wb), 32'(e.wr));
            checkOutput("wb_arrival_cycle", 32'(cyc), 32'(e.cyc));
            if (e.chk_rd) checkOutput("wb_read_data", ram_read_data_mem_wb, e.rdata);
          end
        end else begin
          checkOutput("wb_bubble", 32'({RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb,
                                       addr_err_mem_wb, bus_err_mem_wb, write_reg_mem_wb}),
                      32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  kind;
    logic        mis;
    logic [31:0] alu;
    int          lat;
    rst_n = 1'b0;
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    #3;
    checkOutput("reset_ram", 32'({ram_req, ram_we}), 32'd0);
    checkOutput("reset_ram_addr", ram_addr, 32'h0);
    checkOutput("reset_ram_wdata", ram_wdata, 32'h0);
    checkOutput("reset_stall", 32'(mem_stall), 32'd0);
    checkOutput("reset_wb", 32'({RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb, addr_err_mem_wb,
                                bus_err_mem_wb, write_reg_mem_wb}), 32'd0);
    checkOutput("reset_wb_data", pc_mem_wb | alu_out_mem_wb | ram_read_data_mem_wb, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    $display("[TB] directed sequences");
    applyStimulus(1, 0, 1, 1, 0, 32'h1000, 32'h40, 32'h0, 5'd3, 1, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 0, 0, 32'h1004, 32'h44, 32'h12345678, 5'd0, 3, 32'h0);
    applyStimulus(1, 0, 1, 1, 0, 32'h1008, 32'h41, 32'h0, 5'd4, 1, 32'h0);
    applyStimulus(1, 0, 1, 1, 0, 32'h100C, 32'h48, 32'h0, 5'd6, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 1, 32'h1010, 32'h7, 32'h0, 5'd5, 1, 32'h0);
    applyStimulus(1, 0, 1, 1, 0, 32'h1014, 32'h4C, 32'h0, 5'd7, 2, 32'hCAFEF00D);
    applyStimulus(1, 1, 1, 0, 0, 32'h1018, 32'h50, 32'hA5A5A5A5, 5'd8, T, 32'h0);

    $display("[TB] randomized sequence");
    for (int i = 0; i < 200; i++) begin
      kind = 2'($urandom_range(0, 3));
      mis  = ($urandom_range(0, 5) == 0);
      alu  = ($urandom() & 32'hFFFF_FFFC) | (mis ? 32'($urandom_range(1, 3)) : 32'h0);
      lat  = $urandom_range(1, T + 2);
      if (lat == T + 2) lat = 0;
      applyStimulus(kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0),
                    ($urandom() & 32'hFFFF_FFFC) | 32'h0000_1000, alu, $urandom(),
                    5'($urandom_range(0, 31)), lat, $urandom());
    end
    @(posedge clk);
    #1 driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (4) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset while a request is outstanding");
    @(posedge clk);
    #1;
    ram_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h0, lat: 0, req_cycles: 0});
    driveInputs(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'h80, 32'h0, 5'd9);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ram_req_in_wait", 32'(ram_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ram_req", 32'(ram_req), 32'd0);
    checkOutput("async_reset_wb", 32'({RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb,
                                      addr_err_mem_wb, bus_err_mem_wb, write_reg_mem_wb}), 32'd0);
    checkOutput("async_reset_wb_data", pc_mem_wb | alu_out_mem_wb | ram_read_data_mem_wb, 32'h0);
    exp_q.delete();
    ram_q.delete();
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 32'h3000, 32'h1234, 32'h0, 5'd11, 1, 32'h0);
    @(posedge clk);
    #1 driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (3) @(negedge clk);
    checkOutput("queue_drained_after_reset", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
